iir_cascade: RTL and testbench

- Parametrised successor to the fixed 3-stage first-order IIR chain: NUM_SECT cascaded first-order sections, y[n] = a0*x[n] + a1*x[n-1] - b1*y[n-1].
- One shared signed multiply-accumulate (MAC) unit, time-multiplexed by a sequencer.
- Coefficients live in an addressable register file with readback.
- Adds over the fixed chain: valid/ready sample handshake, signed saturation, and per-section bypass.

---
 rtl/iir_pkg.sv | 28 ++
 rtl/iir_if.sv | 29 ++
 rtl/iir_mac.sv | 42 ++++
 rtl/iir_cascade.sv | 160 ++++++++++++++++
 tb/tb_iir_cascade.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// Shared types and helpers for the cascaded first-order IIR filter.
package iir_pkg;

  localparam logic [1:0] OFS_A0  = 2'd0;
  localparam logic [1:0] OFS_A1  = 2'd1;
  localparam logic [1:0] OFS_B1  = 2'd2;
  localparam logic [1:0] OFS_CTL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MAC0, ST_MAC1, ST_MAC2, ST_WB, ST_OUT
  } state_t;

  typedef enum logic [1:0] {
    MAC_NOP, MAC_LOAD, MAC_ADD, MAC_SUB
  } mac_op_t;

  // Clamp v to the signed range of a w-bit word; callers compare in/out to detect clipping.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat_clamp = hi;
    else if (v < lo) sat_clamp = lo;
    else             sat_clamp = v;
  endfunction

endpackage

// File: rtl/iir_if.sv
// Sample stream, coefficient port and saturation status of the IIR cascade.
interface iir_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [DATA_W-1:0] coef_wdata;
  logic                     coef_we;
  logic signed [DATA_W-1:0] coef_rdata;
  logic                     coef_err;
  logic                     sat_flag;
  logic                     sat_clr;

  modport slave (
    input  in_data, in_valid, out_ready, coef_addr, coef_wdata, coef_we, sat_clr,
    output in_ready, out_data, out_valid, coef_rdata, coef_err, sat_flag
  );

  modport master (
    output in_data, in_valid, out_ready, coef_addr, coef_wdata, coef_we, sat_clr,
    input  in_ready, out_data, out_valid, coef_rdata, coef_err, sat_flag
  );
endinterface

// File: rtl/iir_mac.sv
// Shared signed multiply-accumulate with floor shift and saturation of the accumulator.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11
) (
  input  logic                     clk,
  input  mac_op_t                  i_op,
  input  logic signed [DATA_W-1:0] i_coef,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_res,
  output logic                     o_ovf
);

  localparam int ACC_W = 2 * DATA_W + 2;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [63:0]         w_wide;
  logic signed [63:0]         w_clamp;

  assign w_prod = (2*DATA_W)'(i_coef) * (2*DATA_W)'(i_data);

  // Accumulator stage: the two guard bits absorb the three-term sum without wrap
  always_ff @(posedge clk) begin
    case (i_op)
      MAC_LOAD: r_acc <= ACC_W'(w_prod);
      MAC_ADD:  r_acc <= r_acc + ACC_W'(w_prod);
      MAC_SUB:  r_acc <= r_acc - ACC_W'(w_prod);
      default:  r_acc <= r_acc;
    endcase
  end

  assign w_shr   = r_acc >>> FRAC_W;
  assign w_wide  = 64'(w_shr);
  assign w_clamp = sat_clamp(w_wide, DATA_W);
  assign o_res   = w_clamp[DATA_W-1:0];
  assign o_ovf   = (w_clamp != w_wide);

endmodule

// File: rtl/iir_cascade.sv
// NUM_SECT first-order IIR sections sharing one MAC, with a coefficient file and bypass.
module iir_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 11,
  parameter int NUM_SECT = 3,
  parameter int ADDR_W   = 6
) (
  input logic  clk,
  input logic  reset,
  iir_if.slave bus
);

  localparam int SECT_W = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

  state_t                   r_state;
  logic [SECT_W-1:0]        r_sect;
  logic signed [DATA_W-1:0] r_cur;
  logic signed [DATA_W-1:0] r_x1 [NUM_SECT];
  logic signed [DATA_W-1:0] r_y1 [NUM_SECT];
  logic signed [DATA_W-1:0] r_a0 [NUM_SECT];
  logic signed [DATA_W-1:0] r_a1 [NUM_SECT];
  logic signed [DATA_W-1:0] r_b1 [NUM_SECT];
  logic [NUM_SECT-1:0]      r_byp;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     r_in_ready;
  logic                     r_coef_err;
  logic                     r_sat_flag;

  logic                     w_mapped;
  logic [SECT_W-1:0]        w_csect;
  logic [1:0]               w_ofs;
  logic signed [DATA_W-1:0] w_rdata;
  mac_op_t                  w_op;
  logic signed [DATA_W-1:0] w_coef;
  logic signed [DATA_W-1:0] w_opnd;
  logic signed [DATA_W-1:0] w_res;
  logic                     w_ovf;
  logic                     w_last;
  logic                     w_sat_evt;

  assign w_mapped = {2'b00, bus.coef_addr[ADDR_W-1:2]} < ADDR_W'(NUM_SECT);
  assign w_csect  = SECT_W'(bus.coef_addr[ADDR_W-1:2]);
  assign w_ofs    = bus.coef_addr[1:0];

  always_comb begin
    w_rdata = '0;
    if (w_mapped) begin
      case (w_ofs)
        OFS_A0:  w_rdata = r_a0[w_csect];
        OFS_A1:  w_rdata = r_a1[w_csect];
        OFS_B1:  w_rdata = r_b1[w_csect];
        default: w_rdata = {{(DATA_W-1){1'b0}}, r_byp[w_csect]};
      endcase
    end
  end

  always_comb begin
    w_op   = MAC_NOP;
    w_coef = '0;
    w_opnd = '0;
    case (r_state)
      ST_MAC0: begin w_op = MAC_LOAD; w_coef = r_a0[r_sect]; w_opnd = r_cur;        end
      ST_MAC1: begin w_op = MAC_ADD;  w_coef = r_a1[r_sect]; w_opnd = r_x1[r_sect]; end
      ST_MAC2: begin w_op = MAC_SUB;  w_coef = r_b1[r_sect]; w_opnd = r_y1[r_sect]; end
      default: ;
    endcase
  end

  iir_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
    .clk   (clk),
    .i_op  (w_op),
    .i_coef(w_coef),
    .i_data(w_opnd),
    .o_res (w_res),
    .o_ovf (w_ovf)
  );

  assign w_last    = (r_sect == SECT_W'(NUM_SECT - 1));
  assign w_sat_evt = (r_state == ST_WB) && !r_byp[r_sect] && w_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sect      <= '0;
      r_cur       <= '0;
      r_byp       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_coef_err  <= 1'b0;
      r_sat_flag  <= 1'b0;
      for (int i = 0; i < NUM_SECT; i++) begin
        r_x1[i] <= '0;
        r_y1[i] <= '0;
        r_a0[i] <= ONE;
        r_a1[i] <= '0;
        r_b1[i] <= '0;
      end
    end else begin
      r_coef_err <= bus.coef_we && (r_state != ST_IDLE);
      if (bus.coef_we && (r_state == ST_IDLE) && w_mapped) begin
        case (w_ofs)
          OFS_A0:  r_a0[w_csect]  <= bus.coef_wdata;
          OFS_A1:  r_a1[w_csect]  <= bus.coef_wdata;
          OFS_B1:  r_b1[w_csect]  <= bus.coef_wdata;
          default: r_byp[w_csect] <= bus.coef_wdata[0];
        endcase
      end

      // A clip in the same cycle as sat_clr keeps the flag set
      if (w_sat_evt)        r_sat_flag <= 1'b1;
      else if (bus.sat_clr) r_sat_flag <= 1'b0;

      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_cur      <= bus.in_data;
          r_sect     <= '0;
          r_in_ready <= 1'b0;
          r_state    <= ST_MAC0;
        end
        ST_MAC0: r_state <= ST_MAC1;
        ST_MAC1: r_state <= ST_MAC2;
        ST_MAC2: r_state <= ST_WB;
        ST_WB: begin
          if (!r_byp[r_sect]) begin
            r_x1[r_sect] <= r_cur;
            r_y1[r_sect] <= w_res;
            r_cur        <= w_res;
          end
          if (w_last) begin
            r_out_data  <= r_byp[r_sect] ? r_cur : w_res;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_sect  <= r_sect + 1'b1;
            r_state <= ST_MAC0;
          end
        end
        ST_OUT: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.coef_rdata = w_rdata;
  assign bus.coef_err   = r_coef_err;
  assign bus.sat_flag   = r_sat_flag;

endmodule

// File: tb/tb_iir_cascade.sv
// Bench for iir_cascade: fixed vectors, corner sequences and a random run against a reference model.
module tb_iir_cascade;

  localparam int DW  = 16;
  localparam int FW  = 11;
  localparam int NS  = 3;
  localparam int AW  = 6;
  localparam int LAT = 4 * NS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iir_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  iir_cascade #(.DATA_W(DW), .FRAC_W(FW), .NUM_SECT(NS), .ADDR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_a0 [NS];
  int     m_a1 [NS];
  int     m_b1 [NS];
  bit     m_byp[NS];
  longint m_x1 [NS];
  longint m_y1 [NS];
  bit     m_sat;

  typedef struct { int addr; int wdata; int exp_rd; } cvec_t;
  typedef struct { int din; int dout; } svec_t;
  cvec_t cv[6];
  svec_t sv[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_a0[i] = 1 << FW; m_a1[i] = 0; m_b1[i] = 0; m_byp[i] = 1'b0;
      m_x1[i] = 0; m_y1[i] = 0;
    end
    m_sat = 1'b0;
  endfunction

  function automatic int m_step(input int x);
    longint cur, acc, q;
    cur = x;
    for (int s = 0; s < NS; s++) begin
      if (m_byp[s]) continue;
      acc = longint'(m_a0[s]) * cur + longint'(m_a1[s]) * m_x1[s] - longint'(m_b1[s]) * m_y1[s];
      q = acc >>> FW;
      if (q > 32767) begin q = 32767; m_sat = 1'b1; end
      else if (q < -32768) begin q = -32768; m_sat = 1'b1; end
      m_x1[s] = cur; m_y1[s] = q; cur = q;
    end
    return int'(cur);
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("idle_timeout", longint'(n < 100), 1);
  endtask

  task automatic wr(input int addr, input int data);
    logic signed [DW-1:0] d16;
    wait_idle();
    d16 = DW'(data);
    bus.coef_addr = AW'(addr); bus.coef_wdata = d16; bus.coef_we = 1'b1;
    @(negedge clk); bus.coef_we = 1'b0;
    if (addr / 4 < NS) begin
      case (addr % 4)
        0: m_a0[addr/4] = int'(d16);
        1: m_a1[addr/4] = int'(d16);
        2: m_b1[addr/4] = int'(d16);
        default: m_byp[addr/4] = d16[0];
      endcase
    end
  endtask

  task automatic rd(input int addr, output int v);
    bus.coef_addr = AW'(addr);
    #1 v = int'(bus.coef_rdata);
  endtask

  task automatic wait_out(output int y);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("out_valid_timeout", longint'(n < 100), 1);
    y = int'(bus.out_data);
  endtask

  task automatic send(input int x, output int y, output int lat);
    bit bad;
    wait_idle();
    bus.in_data = DW'(x); bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    lat = 0; bad = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (bus.in_ready) bad = 1'b1;
    chk("in_ready_busy", longint'(bad), 0);
    chk("latency", lat, LAT);
    y = int'(bus.out_data);
  endtask

  initial begin
    int y, lat, v, e, seen;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.coef_we = 1'b0; bus.sat_clr = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_coef_err", longint'(bus.coef_err), 0);
    chk("rst_sat_flag", longint'(bus.sat_flag), 0);
    reset = 1'b0;
    rd(0, v);  chk("rst_a0", v, 2048);
    rd(1, v);  chk("rst_a1", v, 0);
    rd(10, v); chk("rst_b1_s2", v, 0);
    rd(3, v);  chk("rst_ctl", v, 0);

    // Identity pass-through
    send(1000, y, lat);
    chk("identity_out", y, 1000);
    chk("identity_sat", longint'(bus.sat_flag), 0);

    // Coefficient map and readback
    cv = '{'{4, 'h0123, 'h0123}, '{5, -5, -5}, '{6, 'h7FFF, 'h7FFF},
           '{7, 'hFFFF, 1}, '{12, 'h5555, 0}, '{63, 'h1111, 0}};
    for (int i = 0; i < 6; i++) wr(cv[i].addr, cv[i].wdata);
    for (int i = 0; i < 6; i++) begin rd(cv[i].addr, v); chk($sformatf("coef_rd_%0d", cv[i].addr), v, cv[i].exp_rd); end
    rd(0, v); chk("coef_rd_untouched", v, 2048);

    // Decaying first-order response, sections 1-2 bypassed
    do_reset();
    wr(0, 1024); wr(2, 'hFC00); wr(7, 1); wr(11, 1);
    rd(2, v); chk("b1_readback", v, -1024);
    sv = '{'{2048, 1024}, '{0, 512}, '{0, 256}};
    for (int i = 0; i < 3; i++) begin
      send(sv[i].din, y, lat);
      chk($sformatf("decay_%0d", i), y, sv[i].dout);
    end

    // Saturation at both rails and sticky flag
    do_reset();
    wr(0, 'h7FFF);
    send(32767, y, lat);
    chk("sat_pos_out", y, 32767);
    chk("sat_pos_flag", longint'(bus.sat_flag), 1);
    send(-32768, y, lat);
    chk("sat_neg_out", y, -32768);
    @(negedge clk); bus.sat_clr = 1'b1;
    @(negedge clk); bus.sat_clr = 1'b0;
    chk("sat_clr", longint'(bus.sat_flag), 0);

    // sat_clr held while a clip happens: the clip wins that cycle
    wait_idle();
    bus.sat_clr = 1'b1; bus.in_data = DW'(32767); bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("sat_clr_collide", longint'(bus.sat_flag), 1);
    @(posedge clk);
    #1 chk("sat_clr_after", longint'(bus.sat_flag), 0);
    bus.sat_clr = 1'b0;
    wait_out(y);
    chk("sat_collide_out", y, 32767);

    // Write during MAC1 is dropped with a one-cycle error pulse
    do_reset();
    wait_idle();
    bus.in_data = DW'(500); bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.coef_addr = '0; bus.coef_wdata = DW'('h1234); bus.coef_we = 1'b1;
    @(posedge clk); #1;
    chk("coef_err_pulse", longint'(bus.coef_err), 1);
    bus.coef_we = 1'b0;
    @(posedge clk); #1;
    chk("coef_err_clear", longint'(bus.coef_err), 0);
    chk("coef_drop_rd", int'(bus.coef_rdata), 2048);
    wait_out(y);
    chk("coef_drop_out", y, 500);
    wr(0, 'h1234);
    rd(0, v); chk("coef_idle_rd", v, 'h1234);
    chk("coef_idle_err", longint'(bus.coef_err), 0);

    // Output stall
    do_reset();
    bus.out_ready = 1'b0;
    send(700, y, lat);
    chk("stall_first", y, 700);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_data", int'(bus.out_data), 700);
      chk("stall_valid", longint'(bus.out_valid), 1);
      chk("stall_in_ready", longint'(bus.in_ready), 0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", longint'(bus.out_valid), 0);
    chk("release_in_ready", longint'(bus.in_ready), 1);
    send(-700, y, lat);
    chk("after_stall", y, -700);

    // Reset during MAC2 of section 1
    do_reset();
    send(2000, y, lat);
    wait_idle();
    bus.in_data = DW'(3000); bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    @(negedge clk); reset = 1'b0; m_reset();
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen = 1; end
    chk("midrst_no_output", seen, 0);
    wr(1, 1024);
    send(1000, y, lat);
    e = m_step(1000);
    chk("midrst_zero_hist", y, 1000);
    chk("midrst_model", y, e);

    // Random coefficients, bypass and samples against the model
    do_reset();
    for (int s = 0; s < NS; s++) begin
      wr(4*s + 0, int'($urandom_range(0, 4095)) - 2048);
      wr(4*s + 1, int'($urandom_range(0, 2047)) - 1024);
      wr(4*s + 2, int'($urandom_range(0, 2047)) - 1024);
      wr(4*s + 3, int'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      send(v, y, lat);
      e = m_step(v);
      chk($sformatf("rand_out_%0d", i), y, e);
      chk($sformatf("rand_sat_%0d", i), longint'(bus.sat_flag), longint'(m_sat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
